// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scanner: active-low hex
// glyph table, segment bit order and all-off values for segments and anodes.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  // Bit position of each segment inside seg_t (bit0 = a ... bit6 = g).
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam int MAX_DIGITS = 8;

  localparam seg_t            SEG_OFF = 7'h7F;
  localparam logic [MAX_DIGITS-1:0] AN_OFF = '1;

  // Active-low glyphs for 0..F; a cleared bit lights that segment.
  localparam seg_t HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg7_scan_if.sv
// Board-side bundle of the scanner: digit data and controls in, active-low
// segment/anode pins and the frame snapshot pulse out.
interface seg7_scan_if #(
  parameter int DIGITS   = 4,
  parameter int BRIGHT_W = 4
);
  logic [4*DIGITS-1:0]  data;
  logic [DIGITS-1:0]    dp_in;
  logic [DIGITS-1:0]    blank;
  logic [BRIGHT_W-1:0]  bright;
  seg7_pkg::seg_t       seg;
  logic                 dp;
  logic [DIGITS-1:0]    an;
  logic                 frame_tick;

  modport master (
    output data, dp_in, blank, bright,
    input  seg, dp, an, frame_tick
  );

  modport slave (
    input  data, dp_in, blank, bright,
    output seg, dp, an, frame_tick
  );
endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-low seven-segment glyph lookup.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  output seg_t       o_seg
);

  assign o_seg = HEX_SEG[i_nibble];

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed, PWM-dimmed seven-segment scanner with per-frame input
// snapshot. Define SEG7_LZ_BLANK_EN to enable leading-zero suppression.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int DIV      = 400,
  parameter int BRIGHT_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  seg7_scan_if.slave bus
);

  localparam int CNT_W = $clog2(DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int ON_W  = $clog2(DIV + 1);

  logic [CNT_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    r_idx;

  logic [4*DIGITS-1:0] r_sh_data;
  logic [DIGITS-1:0]   r_sh_dp;
  logic [DIGITS-1:0]   r_sh_blank;
  logic [ON_W-1:0]     r_sh_on;

  seg_t                r_seg;
  logic                r_dp;
  logic [DIGITS-1:0]   r_an;
  logic                r_frame_tick;

  logic                w_last_cnt;
  logic                w_snap;
  logic [DIGITS-1:0]   w_lz;
  logic [ON_W-1:0]     w_on_next;
  logic [3:0]          w_nibble;
  seg_t                w_dec_seg;
  logic                w_lit;
  logic [DIGITS-1:0]   w_an_next;

  assign w_last_cnt = (r_cnt == CNT_W'(DIV - 1));
  assign w_snap     = w_last_cnt && (r_idx == IDX_W'(DIGITS - 1));

  // Slot counter and digit index.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_last_cnt) begin
      r_cnt <= '0;
      r_idx <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

`ifdef SEG7_LZ_BLANK_EN
  logic w_lead;

  // Digit 0 is excluded from the walk so a zero value still shows "0".
  // NOTE: every variable in always_comb gets a default first so no path can
  // leave it unassigned and infer a latch; w_lead is a blocking scratch flag.
  always_comb begin
    w_lz   = '0;
    w_lead = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (w_lead && (bus.data[4*i +: 4] == 4'h0)) w_lz[i] = 1'b1;
      else                                         w_lead = 1'b0;
    end
  end
`else
  assign w_lz = '0;
`endif

  assign w_on_next = ON_W'(((int'(bus.bright) + 1) * DIV) >> BRIGHT_W);

  // Frame snapshot; suppression is folded into the stored blank/dp masks.
  // NOTE: shadows reset to "all blank" so the display stays dark until the
  // first snapshot rather than showing power-up garbage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_data  <= '0;
      r_sh_dp    <= '0;
      r_sh_blank <= '1;
      r_sh_on    <= ON_W'(DIV);
    end else if (w_snap) begin
      r_sh_data  <= bus.data;
      r_sh_dp    <= bus.dp_in & ~w_lz;
      r_sh_blank <= bus.blank | w_lz;
      r_sh_on    <= w_on_next;
    end
  end

  assign w_nibble = r_sh_data[{r_idx, 2'b00} +: 4];

  seg7_hex_decode u_dec (
    .i_nibble (w_nibble),
    .o_seg    (w_dec_seg)
  );

  // cnt = 0 is kept dark so the new segment pattern settles before the anode.
  assign w_lit = !r_sh_blank[r_idx] && (r_cnt != '0) && (ON_W'(r_cnt) < r_sh_on);

  always_comb begin
    w_an_next = AN_OFF[DIGITS-1:0];
    if (w_lit) w_an_next[r_idx] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an         <= AN_OFF[DIGITS-1:0];
      r_seg        <= SEG_OFF;
      r_dp         <= 1'b1;
      r_frame_tick <= 1'b0;
    end else begin
      r_an         <= w_an_next;
      r_seg        <= r_sh_blank[r_idx] ? SEG_OFF : w_dec_seg;
      r_dp         <= r_sh_blank[r_idx] | ~r_sh_dp[r_idx];
      r_frame_tick <= w_snap;
    end
  end

  assign bus.an         = r_an;
  assign bus.seg        = r_seg;
  assign bus.dp         = r_dp;
  assign bus.frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan (DIGITS=4, DIV=4, BRIGHT_W=2) against a
// frame/slot timing model built from segment-letter glyph definitions.
module tb_seg7_scan;

  localparam int D  = 4;
  localparam int DV = 4;
  localparam int BW = 2;
  localparam int FRAME = D * DV;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  seg7_scan_if #(.DIGITS(D), .BRIGHT_W(BW)) bus ();

  seg7_scan #(.DIGITS(D), .DIV(DV), .BRIGHT_W(BW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Model: n = clock edges since reset release; shadow copies of inputs.
  int          n;
  logic [15:0] m_data;
  logic [3:0]  m_dp;
  logic [3:0]  m_blank;
  logic [1:0]  m_bright;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s n=%0d observed=%0h expected=%0h", tag, n, obs, exp);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] v);
    string       lit;
    logic [6:0]  r;
    case (v)
      4'h0: lit = "abcdef";  4'h1: lit = "bc";
      4'h2: lit = "abdeg";   4'h3: lit = "abcdg";
      4'h4: lit = "bcfg";    4'h5: lit = "acdfg";
      4'h6: lit = "acdefg";  4'h7: lit = "abc";
      4'h8: lit = "abcdefg"; 4'h9: lit = "abcdfg";
      4'hA: lit = "abcefg";  4'hB: lit = "cdefg";
      4'hC: lit = "adef";    4'hD: lit = "bcdeg";
      4'hE: lit = "adefg";   default: lit = "aefg";
    endcase
    r = 7'h7F;
    for (int i = 0; i < lit.len(); i++) r[int'(lit[i]) - int'("a")] = 1'b0;
    return r;
  endfunction

  task automatic reset_model();
    n        = 0;
    m_data   = '0;
    m_dp     = '0;
    m_blank  = '1;
    m_bright = '1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_an"},  32'(bus.an),         32'hF);
    check({tag, "_seg"}, 32'(bus.seg),        32'h7F);
    check({tag, "_dp"},  32'(bus.dp),         32'h1);
    check({tag, "_ft"},  32'(bus.frame_tick), 32'h0);
  endtask

  // One clock edge: compare outputs for the slot position just registered,
  // then take the model snapshot if that edge closed a frame.
  task automatic step();
    int         s, idx, c, on;
    logic       lead;
    logic [3:0] lz, bl, dpe, exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;
    @(posedge clk);
    n++;
    #1;
    s   = n - 1;
    idx = (s / DV) % D;
    c   = s % DV;
    lz  = '0;
`ifdef SEG7_LZ_BLANK_EN
    lead = 1'b1;
    for (int j = D - 1; j >= 1; j--) begin
      if (lead && m_data[4*j +: 4] == 4'h0) lz[j] = 1'b1;
      else lead = 1'b0;
    end
`else
    lead = 1'b0;
`endif
    bl  = m_blank | lz;
    dpe = m_dp & ~lz;
    on  = ((int'(m_bright) + 1) * DV) >> BW;
    exp_an = 4'hF;
    if (!bl[idx] && c != 0 && c < on) exp_an[idx] = 1'b0;
    exp_seg = bl[idx] ? 7'h7F : glyph(m_data[4*idx +: 4]);
    exp_dp  = bl[idx] ? 1'b1 : ~dpe[idx];
    check("an",         32'(bus.an),         32'(exp_an));
    check("seg",        32'(bus.seg),        32'(exp_seg));
    check("dp",         32'(bus.dp),         32'(exp_dp));
    check("frame_tick", 32'(bus.frame_tick), 32'((n % FRAME) == 0));
    if ((n % FRAME) == 0) begin
      m_data   = bus.data;
      m_dp     = bus.dp_in;
      m_blank  = bus.blank;
      m_bright = bus.bright;
    end
  endtask

  task automatic run(input int k);
    repeat (k) step();
  endtask

  initial begin
    bus.data   = 16'h1234;
    bus.dp_in  = 4'b0000;
    bus.blank  = 4'b0000;
    bus.bright = 2'd3;
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Dark first frame, then 1234 at full brightness.
    run(48);
    bus.bright = 2'd0;
    run(32);
    bus.bright = 2'd1;
    run(32);
    bus.bright = 2'd3;
    run(22);
    // Mid-frame data change must wait for the next snapshot.
    bus.data = 16'hABCD;
    run(40);
    bus.data  = 16'h0070;
    bus.dp_in = 4'b0010;
    run(40);
    bus.blank = 4'b0101;
    run(32);
    bus.blank = 4'b0000;

    // Asynchronous reset while digit 2 is being scanned.
    do step(); while (((n / DV) % D) != 2);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_async");
    @(posedge clk);
    #1;
    check_reset_outputs("rst_hold");
    reset_model();
    @(negedge clk);
    rst_n = 1'b1;
    run(36);

    // Randomised inputs, changed at arbitrary points within frames.
    repeat (400) begin
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 3))
          0:       bus.data   = 16'($urandom);
          1:       bus.dp_in  = 4'($urandom);
          2:       bus.blank  = 4'($urandom) & 4'($urandom);
          default: bus.bright = 2'($urandom);
        endcase
      end
      if ($urandom_range(0, 15) == 0) bus.data[15:8] = 8'h00;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
